binary_down_timer: RTL and testbench

- Programmable down-counting timer: the count-down counterpart to the lab binary up counter.
- Loads a start value, decrements once per clock to zero, then pulses `done`.
- Optionally auto-reloads to run as a periodic tick generator.
- Used as the interval/timeout source for lab FSMs and display-refresh logic.

---
 rtl/binary_down_timer.sv | 101 ++++++++++
 tb/tb_binary_down_timer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/binary_down_timer.sv
// Programmable down-counting timer: loads a start value, counts to zero and
// pulses done; optionally reloads itself to act as a periodic tick source.
module binary_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] q_reg,      q_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             auto_reg,   auto_next;
    logic             done_reg,   done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
            reload_reg <= '0;
            auto_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            reload_reg <= reload_next;
            auto_reg   <= auto_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        reload_next = reload_reg;
        auto_next   = auto_reg;
        done_next   = 1'b0;

        if (start) begin
            if (load_val != '0) begin
                q_next      = load_val;
                reload_next = load_val;
                auto_next   = auto_reload;
                state_next  = RUN;
            end else begin
                // A zero load finishes immediately and never enters RUN.
                q_next     = '0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end else begin
            case (state_reg)
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (q_reg > WIDTH'(1)) begin
                        q_next = q_reg - WIDTH'(1);
                    end else if (q_reg == WIDTH'(1)) begin
                        q_next     = '0;
                        done_next  = 1'b1;
                        state_next = auto_reg ? RUN : IDLE;
                    end else begin
                        // q==0 in RUN only happens in periodic mode.
                        q_next = reload_reg;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                IDLE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign q     = q_reg;
    assign done  = done_reg;
    assign state = state_reg;
    assign busy  = (state_reg == RUN) || (state_reg == PAUSED);

endmodule

// File: tb/tb_binary_down_timer.sv
// Directed bench for binary_down_timer: each step drives inputs, clocks once
// and compares {state, busy, done, q} against hand-computed values.
module tb_binary_down_timer;

    localparam int WIDTH = 4;
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    binary_down_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .auto_reload(auto_reload),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clock one edge, then sample 1ns later and compare all outputs at once.
    task automatic step(input string tag, input logic [1:0] exp_state,
                        input logic exp_done, input int exp_q);
        logic [7:0] got;
        logic [7:0] exp;
        logic [WIDTH-1:0] eq;
        @(posedge clk);
        #1;
        eq  = exp_q[WIDTH-1:0];
        got = {state, busy, done, q};
        exp = {exp_state, (exp_state != S_IDLE), exp_done, eq};
        check(tag, {24'h0, got}, {24'h0, exp});
        $display("%0t %s: state=%0d busy=%0b done=%0b q=%0d", $time, tag, state, busy, done, q);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; auto_reload = 1'b0; load_val = '0;
        #1;
        step("reset0", S_IDLE, 1'b0, 0);
        step("reset1", S_IDLE, 1'b0, 0);
        rst = 1'b0;

        // One-shot from 5
        start = 1'b1; load_val = 4'd5;
        step("os_load", S_RUN, 1'b0, 5);
        start = 1'b0; load_val = 4'd0;
        for (int v = 4; v >= 1; v--) step("os_dec", S_RUN, 1'b0, v);
        step("os_done", S_IDLE, 1'b1, 0);
        step("os_after", S_IDLE, 1'b0, 0);
        step("os_after2", S_IDLE, 1'b0, 0);

        // Periodic from 3
        start = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
        step("per_load", S_RUN, 1'b0, 3);
        start = 1'b0; auto_reload = 1'b0; load_val = 4'd9;
        for (int p = 0; p < 2; p++) begin
            step("per_2", S_RUN, 1'b0, 2);
            step("per_1", S_RUN, 1'b0, 1);
            step("per_0", S_RUN, 1'b1, 0);
            step("per_rl", S_RUN, 1'b0, 3);
        end
        rst = 1'b1;
        step("per_rst", S_IDLE, 1'b0, 0);
        rst = 1'b0;

        // Pause at q=4
        start = 1'b1; load_val = 4'd6;
        step("pz_load", S_RUN, 1'b0, 6);
        start = 1'b0;
        step("pz_5", S_RUN, 1'b0, 5);
        step("pz_4", S_RUN, 1'b0, 4);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) step("pz_hold", S_PAUSED, 1'b0, 4);
        pause = 1'b0;
        step("pz_resume", S_RUN, 1'b0, 4);
        for (int v = 3; v >= 1; v--) step("pz_dec", S_RUN, 1'b0, v);
        step("pz_done", S_IDLE, 1'b1, 0);

        // Pause exactly when q==1 defers done
        start = 1'b1; load_val = 4'd2;
        step("p1_load", S_RUN, 1'b0, 2);
        start = 1'b0;
        step("p1_1", S_RUN, 1'b0, 1);
        pause = 1'b1;
        step("p1_hold", S_PAUSED, 1'b0, 1);
        pause = 1'b0;
        step("p1_resume", S_RUN, 1'b0, 1);
        step("p1_done", S_IDLE, 1'b1, 0);

        // Restart mid-count; load_val changes without start are ignored
        start = 1'b1; load_val = 4'd9;
        step("rs_load", S_RUN, 1'b0, 9);
        start = 1'b0; load_val = 4'd12; auto_reload = 1'b1;
        for (int v = 8; v >= 5; v--) step("rs_dec", S_RUN, 1'b0, v);
        start = 1'b1; load_val = 4'd2; auto_reload = 1'b0;
        step("rs_restart", S_RUN, 1'b0, 2);
        start = 1'b0;
        step("rs_1", S_RUN, 1'b0, 1);
        step("rs_done", S_IDLE, 1'b1, 0);
        step("rs_idle", S_IDLE, 1'b0, 0);

        // Zero load: immediate done, never busy
        start = 1'b1; load_val = 4'd0; auto_reload = 1'b1;
        step("z_done", S_IDLE, 1'b1, 0);
        start = 1'b0; auto_reload = 1'b0;
        step("z_clear", S_IDLE, 1'b0, 0);

        // Max load: 15 decrements before done
        start = 1'b1; load_val = 4'd15;
        step("mx_load", S_RUN, 1'b0, 15);
        start = 1'b0;
        for (int v = 14; v >= 1; v--) step("mx_dec", S_RUN, 1'b0, v);
        step("mx_done", S_IDLE, 1'b1, 0);

        // Reset beats start mid-count
        start = 1'b1; load_val = 4'd9;
        step("rm_load", S_RUN, 1'b0, 9);
        start = 1'b0;
        step("rm_8", S_RUN, 1'b0, 8);
        step("rm_7", S_RUN, 1'b0, 7);
        rst = 1'b1; start = 1'b1; load_val = 4'd5;
        step("rm_rst", S_IDLE, 1'b0, 0);
        rst = 1'b0; start = 1'b0;
        step("rm_idle", S_IDLE, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
